// File: rtl/d_ff_sync_pkg.sv
// d_ff_sync_pkg
//   Shared defaults and types for the d_ff_sync register slice.
//   D_FF_SYNC_DEF_WIDTH  : default data width (1 bit)
//   D_FF_SYNC_DEF_STAGES : default number of cascaded stages (1)
//   d_ff_sync_data_t     : data word at the default width
//   d_ff_sync_cfg_ok()   : legality check for WIDTH/STAGES, used at elaboration
package d_ff_sync_pkg;

    localparam int D_FF_SYNC_DEF_WIDTH  = 1;
    localparam int D_FF_SYNC_DEF_STAGES = 1;

    typedef logic [D_FF_SYNC_DEF_WIDTH-1:0] d_ff_sync_data_t;

    // Both dimensions must be at least one; anything else has no sensible
    // hardware meaning (zero-width bus or zero-latency "register").
    function automatic bit d_ff_sync_cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1);
    endfunction

endpackage

// File: rtl/d_ff_sync_if.sv
// d_ff_sync_if
//   Data bundle for the d_ff_sync register chain.
//   Parameter WIDTH : data width in bits.
//   d  : data into the chain (driven by master)
//   q  : data out of the last stage (driven by slave)
//   ce : clock enable, only present when D_FF_SYNC_CE_EN is defined
//   Modports: master (the producer/consumer around the chain), slave (the chain).
import d_ff_sync_pkg::*;

interface d_ff_sync_if #(
    parameter int WIDTH = D_FF_SYNC_DEF_WIDTH
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
`ifdef D_FF_SYNC_CE_EN
    logic             ce;

    modport master (output d, output ce, input  q);
    modport slave  (input  d, input  ce, output q);
`else
    modport master (output d, input  q);
    modport slave  (input  d, output q);
`endif
endinterface

// File: rtl/d_ff_sync_stage.sv
// d_ff_sync_stage
//   One WIDTH-bit register with synchronous active-high reset to RST_VAL and
//   a load enable. Reset wins over the enable.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   en  : load enable, active-high (hold when low)
//   d   : next data
//   q   : registered data
import d_ff_sync_pkg::*;

module d_ff_sync_stage #(
    parameter int               WIDTH   = D_FF_SYNC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/d_ff_sync.sv
// d_ff_sync
//   Parameterizable D-type register chain: d is captured on the rising edge
//   and emerges on q after STAGES enabled edges. q comes straight from the
//   last stage register, so there is no combinational path to the output.
//   Parameters:
//     WIDTH   : data width, >= 1
//     STAGES  : number of cascaded stages (latency), >= 1
//     RST_VAL : value loaded into every stage while rst is high
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous reset, active-high, overrides ce
//     bus : d_ff_sync_if.slave carrying d, q (and ce)
//   Build option:
//     D_FF_SYNC_CE_EN : when defined, bus.ce gates every stage update; when
//                       undefined the chain advances on every non-reset edge.
import d_ff_sync_pkg::*;

module d_ff_sync #(
    parameter int               WIDTH   = D_FF_SYNC_DEF_WIDTH,
    parameter int               STAGES  = D_FF_SYNC_DEF_STAGES,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    d_ff_sync_if.slave  bus
);

    generate
        if (!d_ff_sync_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
            $error("d_ff_sync: WIDTH (%0d) and STAGES (%0d) must both be >= 1",
                   WIDTH, STAGES);
        end
    endgenerate

    logic             stage_en;
    logic [WIDTH-1:0] stage_q [STAGES];

`ifdef D_FF_SYNC_CE_EN
    assign stage_en = bus.ce;
`else
    assign stage_en = 1'b1;
`endif

    // A single shared enable freezes the whole chain together, so a disabled
    // edge never opens a bubble between stages.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_d;

            if (gi == 0) begin : g_head
                assign stage_d = bus.d;
            end else begin : g_link
                assign stage_d = stage_q[gi-1];
            end

            d_ff_sync_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (stage_en),
                .d   (stage_d),
                .q   (stage_q[gi])
            );
        end
    endgenerate

    assign bus.q = stage_q[STAGES-1];

endmodule

// File: tb/tb_d_ff_sync.sv
// tb_d_ff_sync
//   Self-checking bench for d_ff_sync. Four instances share clk/rst/ce:
//     0: WIDTH=1,  STAGES=1, RST_VAL=0
//     1: WIDTH=1,  STAGES=1, RST_VAL=1
//     2: WIDTH=8,  STAGES=3, RST_VAL=0x00
//     3: WIDTH=16, STAGES=2, RST_VAL=0xA5A5
//   Each driven sample is pushed into a per-instance scoreboard queue; the
//   entry popped at the same enabled edge is the value q must show after it.
//   Build with +define+D_FF_SYNC_CE_EN to exercise the clock enable.
import d_ff_sync_pkg::*;

module tb_d_ff_sync;

    localparam int               N_DUT          = 4;
    localparam int               STG  [N_DUT]   = '{1, 1, 3, 2};
    localparam logic [15:0]      RV   [N_DUT]   = '{16'h0000, 16'h0001, 16'h0000, 16'hA5A5};
    localparam logic [15:0]      MSK  [N_DUT]   = '{16'h0001, 16'h0001, 16'h00FF, 16'hFFFF};

    logic clk;
    logic rst;

    d_ff_sync_if #(.WIDTH(1))  if_a ();
    d_ff_sync_if #(.WIDTH(1))  if_b ();
    d_ff_sync_if #(.WIDTH(8))  if_c ();
    d_ff_sync_if #(.WIDTH(16)) if_d ();

    d_ff_sync #(.WIDTH(1), .STAGES(1), .RST_VAL(1'b0)) u_dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    d_ff_sync #(.WIDTH(1), .STAGES(1), .RST_VAL(1'b1)) u_dut_b (
        .clk (clk), .rst (rst), .bus (if_b)
    );
    d_ff_sync #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00)) u_dut_c (
        .clk (clk), .rst (rst), .bus (if_c)
    );
    d_ff_sync #(.WIDTH(16), .STAGES(2), .RST_VAL(16'hA5A5)) u_dut_d (
        .clk (clk), .rst (rst), .bus (if_d)
    );

    logic [15:0] got [N_DUT];
    assign got[0] = 16'(if_a.q);
    assign got[1] = 16'(if_b.q);
    assign got[2] = 16'(if_c.q);
    assign got[3] = 16'(if_d.q);

    logic [15:0] sb      [N_DUT][$];
    logic [15:0] exp_q   [N_DUT];
    bit          started;
    int          n_checks;
    int          n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got_v, input logic [15:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got_v, exp_v, $time);
        end
    endtask

    // Called at a falling edge: drive, confirm q has not moved mid-cycle,
    // advance the scoreboard, then compare after the rising edge.
    task automatic cycle(input logic r, input logic c, input logic [15:0] v);
        logic en;
        rst      = r;
        if_a.d   = v[0];
        if_b.d   = v[0];
        if_c.d   = v[7:0];
        if_d.d   = v;
`ifdef D_FF_SYNC_CE_EN
        if_a.ce  = c;
        if_b.ce  = c;
        if_c.ce  = c;
        if_d.ce  = c;
        en       = c;
`else
        en       = 1'b1;
`endif
        #2;
        if (started) begin
            for (int i = 0; i < N_DUT; i++)
                check($sformatf("mid_cycle[%0d]", i), got[i], exp_q[i]);
        end
        for (int i = 0; i < N_DUT; i++) begin
            if (r) begin
                sb[i].delete();
                for (int k = 0; k < STG[i] - 1; k++)
                    sb[i].push_back(RV[i]);
                exp_q[i] = RV[i];
            end else if (en) begin
                sb[i].push_back(v & MSK[i]);
                exp_q[i] = sb[i].pop_front();
            end
        end
        if (r) started = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++)
            check($sformatf("%s[%0d]", r ? "reset" : (en ? "data" : "hold"), i), got[i], exp_q[i]);
        $display("txn rst=%0b ce=%0b d=%h q=%h/%h/%h/%h", r, c, v,
                 got[0], got[1], got[2], got[3]);
        @(negedge clk);
    endtask

    // Short reset pulse entirely between edges: must leave q untouched.
    task automatic rst_glitch();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < N_DUT; i++)
            check($sformatf("glitch[%0d]", i), got[i], exp_q[i]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        started  = 1'b0;
        rst      = 1'b0;
        if_a.d = '0; if_b.d = '0; if_c.d = '0; if_d.d = '0;
`ifdef D_FF_SYNC_CE_EN
        if_a.ce = 1'b1; if_b.ce = 1'b1; if_c.ce = 1'b1; if_d.ce = 1'b1;
`endif
        for (int i = 0; i < N_DUT; i++) exp_q[i] = 'x;
        @(negedge clk);

        // Reset with d high: q goes to RST_VAL, not d.
        cycle(1'b1, 1'b1, 16'hFFFF);

        // Bit pattern 1,0,1,1,0 on bit 0; 0x11,0x22,0x33 through the 3-stage chain.
        cycle(1'b0, 1'b1, 16'hFF11);
        cycle(1'b0, 1'b1, 16'h0022);
        cycle(1'b0, 1'b1, 16'hFF33);
        cycle(1'b0, 1'b1, 16'h1245);
        cycle(1'b0, 1'b1, 16'h0000);

        // Glitch-free reset behaviour: q=1 held until the reset edge.
        cycle(1'b0, 1'b1, 16'h0001);
        rst_glitch();
        cycle(1'b0, 1'b1, 16'h0003);
        cycle(1'b1, 1'b1, 16'h0001);
        cycle(1'b0, 1'b1, 16'h0001);

        // Mid-stream reset while the 3-stage chain is full.
        cycle(1'b0, 1'b1, 16'h0044);
        cycle(1'b0, 1'b1, 16'h0055);
        cycle(1'b1, 1'b1, 16'h0066);
        cycle(1'b0, 1'b1, 16'h0077);
        cycle(1'b0, 1'b1, 16'h0088);
        cycle(1'b0, 1'b1, 16'h0099);

        // All-ones / all-zeros through the wide instance.
        cycle(1'b0, 1'b1, 16'hFFFF);
        cycle(1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b1, 16'h0000);

`ifdef D_FF_SYNC_CE_EN
        // Enable low for two cycles while d changes: chain frozen.
        cycle(1'b0, 1'b1, 16'h1234);
        cycle(1'b0, 1'b0, 16'h5678);
        cycle(1'b0, 1'b0, 16'h9ABC);
        cycle(1'b0, 1'b1, 16'hDEF0);
        cycle(1'b0, 1'b1, 16'h0F0F);
        // Reset still applies with enable low.
        cycle(1'b1, 1'b0, 16'hFFFF);
        cycle(1'b0, 1'b0, 16'h7777);
        cycle(1'b0, 1'b1, 16'h3C3C);
`endif

        // Mixed random traffic with occasional reset and enable drops.
        for (int n = 0; n < 40; n++) begin
            cycle(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "tb_d_ff_sync watchdog expired");
    end

endmodule
